// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, samples memory after RD_LAT cycles and buffers {PC, word} in order.
// Optional macro IFU_BRANCH_PREDECODE_EN steers the next fetch to the target of a pushed B imm26 word.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [63:0] Address,
  input  logic [31:0] Data,
  output logic [31:0] Instr,
  output logic [63:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(QDEPTH);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t        stateQ, stateD;
  logic [63:0]   pcQ, pcD;
  logic [CW-1:0] cntQ, cntD;
  logic [AW-1:0] rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
  logic [AW:0]   countQ, countD;
  logic [31:0]   instrQ, instrD;
  logic [63:0]   instrPcQ, instrPcD;
  logic          validQ, validD;
  logic [31:0]   memWordQ [QDEPTH];
  logic [63:0]   memPcQ   [QDEPTH];
  logic          full, pop, push, fetchDone;
  logic [63:0]   nextPc;

`ifdef IFU_BRANCH_PREDECODE_EN
  always_comb begin
    if (Data[31:26] == 6'b000101) nextPc = pcQ + {{36{Data[25]}}, Data[25:0], 2'b00};
    else                          nextPc = pcQ + 64'd4;
  end
`else
  assign nextPc = pcQ + 64'd4;
`endif

  // Full is judged on the pre-pop occupancy, so a pop never frees a slot for a same-cycle push.
  always_comb begin
    full      = (countQ == OCC_FULL);
    pop       = validQ && InstrReady;
    fetchDone = (stateQ == HOLD) || (cntQ == CNT_LAST);
    push      = fetchDone && !full && !Redirect;

    stateD   = stateQ;
    pcD      = pcQ;
    cntD     = cntQ;
    rdPtrD   = rdPtrQ;
    wrPtrD   = wrPtrQ;
    countD   = countQ;
    instrD   = instrQ;
    instrPcD = instrPcQ;
    validD   = validQ;

    if (Redirect) begin
      pcD    = RedirectPC & ~64'h3;
      cntD   = '0;
      stateD = FETCH;
      rdPtrD = '0;
      wrPtrD = '0;
      countD = '0;
      validD = 1'b0;
    end else begin
      unique case (stateQ)
        FETCH: begin
          if (cntQ == CNT_LAST) begin
            if (!full) begin
              pcD  = nextPc;
              cntD = '0;
            end else begin
              stateD = HOLD;
            end
          end else begin
            cntD = cntQ + CW'(1);
          end
        end
        HOLD: begin
          if (!full) begin
            pcD    = nextPc;
            cntD   = '0;
            stateD = FETCH;
          end
        end
        default: stateD = FETCH;
      endcase

      if (push) wrPtrD = wrPtrQ + AW'(1);
      if (pop)  rdPtrD = rdPtrQ + AW'(1);
      countD = countQ + (AW+1)'(push) - (AW+1)'(pop);
      validD = (countD != '0);

      // A push into an empty (post-pop) queue becomes the head directly.
      if (validD) begin
        if (push && (wrPtrQ == rdPtrD)) begin
          instrD   = Data;
          instrPcD = pcQ;
        end else begin
          instrD   = memWordQ[rdPtrD];
          instrPcD = memPcQ[rdPtrD];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      stateQ   <= FETCH;
      pcQ      <= RESET_PC;
      cntQ     <= '0;
      rdPtrQ   <= '0;
      wrPtrQ   <= '0;
      countQ   <= '0;
      instrQ   <= '0;
      instrPcQ <= '0;
      validQ   <= 1'b0;
    end else begin
      stateQ   <= stateD;
      pcQ      <= pcD;
      cntQ     <= cntD;
      rdPtrQ   <= rdPtrD;
      wrPtrQ   <= wrPtrD;
      countQ   <= countD;
      instrQ   <= instrD;
      instrPcQ <= instrPcD;
      validQ   <= validD;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      memWordQ[wrPtrQ] <= Data;
      memPcQ[wrPtrQ]   <= pcQ;
    end
  end

  assign Address    = pcQ;
  assign Instr      = instrQ;
  assign InstrPC    = instrPcQ;
  assign InstrValid = validQ;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected {PC, word} stream comes from a sequential-fetch
// reference model over a behavioural memory; a negedge monitor checks every word decode accepts.
module tb_instruction_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] Address;
  logic [31:0] Data;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        Redirect;
  logic [63:0] RedirectPC;

  int testsRun    = 0;
  int testsFailed = 0;
  int retireCount = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;
  exp_t expQ[$];

  instruction_fetch_unit dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Address   (Address),
    .Data      (Data),
    .Instr     (Instr),
    .InstrPC   (InstrPC),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC)
  );

  always #5 CLK = ~CLK;

  // Behavioural instruction memory; random words keep bit 31 set so they never decode as B imm26.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    logic [31:0] h;
    case (a)
      64'h0:  return 32'hF84003E9;
      64'h4:  return 32'hF84083EA;
      64'h28: return 32'h17FFFFFD;
      64'h34: return 32'hCB090129;
      default: begin
        h = (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A1234;
        return h | 32'h8000_0000;
      end
    endcase
  endfunction

  assign Data = memWord(Address);

  // Next fetch address of the program-order reference stream.
  function automatic logic [63:0] refNext(input logic [63:0] pc, input logic [31:0] word);
    logic isBranch;
`ifdef IFU_BRANCH_PREDECODE_EN
    isBranch = (word[31:26] == 6'b000101);
`else
    isBranch = 1'b0;
`endif
    if (isBranch) return pc + {{36{word[25]}}, word[25:0], 2'b00};
    return pc + 64'd4;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetScoreboard(input logic [63:0] startPc);
    logic [63:0] pc;
    exp_t e;
    expQ.delete();
    pc = startPc;
    for (int i = 0; i < 64; i++) begin
      e.pc   = pc;
      e.word = memWord(pc);
      expQ.push_back(e);
      pc = refNext(pc, e.word);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_addr"},  Address, RESET_PC);
    checkOutput({tag, "_valid"}, 64'(InstrValid), 64'd0);
    checkOutput({tag, "_instr"}, 64'(Instr), 64'd0);
    checkOutput({tag, "_pc"},    InstrPC, 64'd0);
  endtask

  // Drive one cycle of inputs just after the clock edge; a redirect consumed on that edge restarts the model.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [63:0] rpc);
    @(posedge CLK);
    #1;
    if (Redirect) begin
      resetScoreboard(RedirectPC & ~64'h3);
      checkOutput("redirect_valid", 64'(InstrValid), 64'd0);
      checkOutput("redirect_addr", Address, RedirectPC & ~64'h3);
    end
    InstrReady = rdy;
    Redirect   = redir;
    RedirectPC = rpc;
  endtask

  // Reset is raised between clock edges so the outputs must clear without a clock.
  task automatic doReset(input string tag, input logic rdy);
    @(posedge CLK);
    #3;
    Reset      = 1'b1;
    Redirect   = 1'b0;
    InstrReady = rdy;
    #1;
    checkReset(tag);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    resetScoreboard(RESET_PC);
  endtask

  // Monitor: every accepted head must be the next expected word; a stalled head must stay put.
  initial begin
    logic        prevHold;
    logic [31:0] heldWord;
    logic [63:0] heldPc;
    exp_t        e;
    prevHold = 1'b0;
    heldWord = '0;
    heldPc   = '0;
    forever begin
      @(negedge CLK);
      if (Reset) begin
        prevHold = 1'b0;
      end else begin
        if (prevHold) begin
          checkOutput("hold_valid", 64'(InstrValid), 64'd1);
          checkOutput("hold_instr", 64'(Instr), 64'(heldWord));
          checkOutput("hold_pc", InstrPC, heldPc);
        end
        if (InstrValid && InstrReady) begin
          if (expQ.size() == 0) begin
            checkOutput("scoreboard_underflow", InstrPC, 64'hDEAD_DEAD_DEAD_DEAD);
          end else begin
            e = expQ.pop_front();
            checkOutput("retire_pc", InstrPC, e.pc);
            checkOutput("retire_word", 64'(Instr), 64'(e.word));
          end
          retireCount++;
        end
        prevHold = InstrValid && !InstrReady && !Redirect;
        heldWord = Instr;
        heldPc   = InstrPC;
      end
    end
  end

  initial begin
    int          base;
    int          since;
    logic        rdy;
    logic        redir;
    logic [63:0] rpc;

    Reset      = 1'b1;
    InstrReady = 1'b1;
    Redirect   = 1'b0;
    RedirectPC = '0;
    #2;
    checkReset("reset_init");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    resetScoreboard(RESET_PC);

    // Sequential fetch with decode always ready: each address held for two cycles.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("seq_addr", Address, RESET_PC + 64'(4 * (k / 2)));
      if (k == 1) checkOutput("first_valid_early", 64'(InstrValid), 64'd0);
      if (k == 2) begin
        checkOutput("first_valid", 64'(InstrValid), 64'd1);
        checkOutput("first_instr", 64'(Instr), 64'hF84003E9);
        checkOutput("first_pc", InstrPC, 64'h0);
      end
      if (k == 4) begin
        checkOutput("second_instr", 64'(Instr), 64'hF84083EA);
        checkOutput("second_pc", InstrPC, 64'h4);
      end
    end

    // Decode stalled from reset: queue fills, fetch holds at 0x10.
    doReset("reset_pre_stall", 1'b0);
    repeat (12) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("stall_addr", Address, 64'h10);
    checkOutput("stall_valid", 64'(InstrValid), 64'd1);
    checkOutput("stall_instr", 64'(Instr), 64'hF84003E9);
    checkOutput("stall_pc", InstrPC, 64'h0);
    base = retireCount;
    repeat (14) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("stall_drain", 64'(retireCount - base >= 6), 64'd1);

    // Stall again into HOLD, then reset in the middle of a cycle.
    repeat (14) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("hold_again_valid", 64'(InstrValid), 64'd1);
    doReset("reset_mid_hold", 1'b0);

    // Three entries queued, then redirect to an unaligned target.
    repeat (6) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("pre_redirect_valid", 64'(InstrValid), 64'd1);
    applyStimulus(1'b0, 1'b1, 64'h36);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("refill_valid", 64'(InstrValid), 64'd1);
    checkOutput("refill_instr", 64'(Instr), 64'hCB090129);
    checkOutput("refill_pc", InstrPC, 64'h34);

    // Fetch of the B imm26 word at 0x28.
    applyStimulus(1'b1, 1'b1, 64'h28);
    repeat (3) applyStimulus(1'b1, 1'b0, '0);
`ifdef IFU_BRANCH_PREDECODE_EN
    checkOutput("branch_next_addr", Address, 64'h1C);
`else
    checkOutput("branch_next_addr", Address, 64'h2C);
`endif

    // Randomised ready/redirect traffic with one asynchronous reset mid-fetch.
    base  = retireCount;
    since = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        doReset("reset_mid_fetch", 1'b1);
        since = 0;
      end
      rdy   = ($urandom_range(3) != 0);
      redir = (i != 699) && (($urandom_range(15) == 0) || (since > 100));
      if ($urandom_range(3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(255));
      else                        rpc = {$urandom(), $urandom()};
      since = redir ? 0 : since + 1;
      applyStimulus(rdy, redir, rpc);
    end
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("random_progress", 64'(retireCount - base > 200), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
